// File: rtl/noise_stats_monitor.sv
// noise_stats_monitor: windowed statistics checker for a signed fixed-point
// noise stream. Accumulates sum, sum of squares, min, max and tail count over
// 2^LOG2_N samples, then reports a rounded mean and variance on a held result port.
module noise_stats_monitor #(
   parameter int unsigned DATA_W   = 16,
   parameter int unsigned FRAC_W   = 11,
   parameter int unsigned LOG2_N   = 10,
   parameter int unsigned TAIL_THR = 6144
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  clear,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic [DATA_W-1:0]     s_data,
   output logic                  busy,
   output logic                  r_valid,
   input  logic                  r_ready,
   output logic [DATA_W-1:0]     r_mean,
   output logic [2*DATA_W-1:0]   r_var,
   output logic [DATA_W-1:0]     r_min,
   output logic [DATA_W-1:0]     r_max,
   output logic [LOG2_N:0]       r_tail
);

   localparam int unsigned SUM_W  = DATA_W + LOG2_N;
   localparam int unsigned PROD_W = 2 * DATA_W;
   localparam int unsigned SQ_W   = PROD_W + LOG2_N;
   localparam int unsigned BIT_W  = $clog2(DATA_W + 1);
   localparam int unsigned HALF   = 1 << (LOG2_N - 1);

   localparam logic [DATA_W-1:0] MAX_CODE = {1'b0, {(DATA_W-1){1'b1}}};
   localparam logic [DATA_W-1:0] MIN_CODE = {1'b1, {(DATA_W-1){1'b0}}};
   localparam logic [DATA_W-1:0] NEG_MAX  = {1'b1, {(DATA_W-2){1'b0}}, 1'b1};

   // Fraction bits only give the samples their meaning; they must leave a sign bit.
   if (FRAC_W >= DATA_W) begin : g_frac_chk
      $error("FRAC_W must be smaller than DATA_W");
   end

   typedef enum logic [2:0] {
      S_IDLE, S_ACCUM, S_ROUND, S_SQR, S_SUB, S_REPORT
   } state_t;

   state_t state_q, state_d;

   logic signed [SUM_W-1:0]  sum_q;
   logic [SQ_W-1:0]          sumsq_q;
   logic signed [DATA_W-1:0] min_q, max_q;
   logic [LOG2_N:0]          tail_q;
   logic [LOG2_N-1:0]        cnt_q;
   logic [DATA_W-1:0]        mean_q;
   logic [PROD_W-1:0]        ex2_q;
   logic [PROD_W-1:0]        mcand_q;
   logic [DATA_W-1:0]        mplr_q;
   logic [PROD_W-1:0]        sq_q;
   logic [BIT_W-1:0]         bit_q;

   logic                     start_c, xfer_c, last_c, tail_c;
   logic signed [DATA_W-1:0] samp_c;
   logic [DATA_W-1:0]        mag_c;
   logic signed [PROD_W-1:0] prod_c;
   logic signed [SUM_W:0]    rnd_sum_c, mean_sh_c;
   logic [SUM_W-DATA_W+1:0]  mean_hi_c;
   logic [DATA_W-1:0]        mean_c, mean_abs_c;
   logic [SQ_W:0]            rnd_sq_c, ex2_sh_c;
   logic [PROD_W-1:0]        ex2_c, var_c;

   // Per-sample terms: transfer qualifiers, saturated magnitude, square.
   always_comb begin
      start_c = start & ~clear;
      xfer_c  = s_valid & s_ready;
      last_c  = xfer_c & (cnt_q == '1);
      samp_c  = s_data;
      mag_c   = s_data;
      if (s_data[DATA_W-1]) begin
         mag_c = (s_data == MIN_CODE) ? MAX_CODE : (~s_data + DATA_W'(1));
      end
      tail_c  = (mag_c >= DATA_W'(TAIL_THR));
      prod_c  = PROD_W'(samp_c) * PROD_W'(samp_c);
   end

   // Window reduction: rounded, saturated mean and E[x^2], then the final variance.
   always_comb begin
      rnd_sum_c  = (SUM_W+1)'(sum_q) + (SUM_W+1)'(HALF);
      mean_sh_c  = rnd_sum_c >>> LOG2_N;
      mean_hi_c  = mean_sh_c[SUM_W:DATA_W-1];
      mean_c     = mean_sh_c[DATA_W-1:0];
      if (!((&mean_hi_c) || (mean_hi_c == '0))) begin
         mean_c = mean_sh_c[SUM_W] ? MIN_CODE : MAX_CODE;
      end
      mean_abs_c = mean_c[DATA_W-1] ? (~mean_c + DATA_W'(1)) : mean_c;
      rnd_sq_c   = (SQ_W+1)'(sumsq_q) + (SQ_W+1)'(HALF);
      ex2_sh_c   = rnd_sq_c >> LOG2_N;
      ex2_c      = (|ex2_sh_c[SQ_W:PROD_W]) ? '1 : ex2_sh_c[PROD_W-1:0];
      var_c      = (ex2_q >= sq_q) ? (ex2_q - sq_q) : '0;
   end

   // Next-state logic; clear overrides every other request.
   always_comb begin
      state_d = state_q;
      if (clear) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE:   if (start) state_d = S_ACCUM;
            S_ACCUM:  if (last_c) state_d = S_ROUND;
            S_ROUND:  state_d = S_SQR;
            S_SQR:    if (bit_q == BIT_W'(DATA_W - 1)) state_d = S_SUB;
            S_SUB:    state_d = S_REPORT;
            S_REPORT: if (r_ready) state_d = S_IDLE;
            default:  state_d = S_IDLE;
         endcase
      end
   end

   // State register with handshake/status outputs registered from the next state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         s_ready <= 1'b0;
         busy    <= 1'b0;
         r_valid <= 1'b0;
      end else begin
         state_q <= state_d;
         s_ready <= (state_d == S_ACCUM);
         busy    <= (state_d != S_IDLE);
         r_valid <= (state_d == S_REPORT);
      end
   end

   // Datapath: accumulate, round, shift-add square of |mean|, publish results.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_q   <= '0;
         sumsq_q <= '0;
         min_q   <= '0;
         max_q   <= '0;
         tail_q  <= '0;
         cnt_q   <= '0;
         mean_q  <= '0;
         ex2_q   <= '0;
         mcand_q <= '0;
         mplr_q  <= '0;
         sq_q    <= '0;
         bit_q   <= '0;
         r_mean  <= '0;
         r_var   <= '0;
         r_min   <= '0;
         r_max   <= '0;
         r_tail  <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start_c) begin
                  sum_q   <= '0;
                  sumsq_q <= '0;
                  min_q   <= MAX_CODE;
                  max_q   <= NEG_MAX;
                  tail_q  <= '0;
                  cnt_q   <= '0;
               end
            end
            S_ACCUM: begin
               if (xfer_c) begin
                  sum_q   <= sum_q + SUM_W'(samp_c);
                  sumsq_q <= sumsq_q + SQ_W'($unsigned(prod_c));
                  if (samp_c < min_q) min_q <= samp_c;
                  if (samp_c > max_q) max_q <= samp_c;
                  tail_q  <= tail_q + (LOG2_N+1)'(tail_c);
                  cnt_q   <= cnt_q + LOG2_N'(1);
               end
            end
            S_ROUND: begin
               mean_q  <= mean_c;
               ex2_q   <= ex2_c;
               mplr_q  <= mean_abs_c;
               mcand_q <= PROD_W'(mean_abs_c);
               sq_q    <= '0;
               bit_q   <= '0;
            end
            S_SQR: begin
               if (mplr_q[0]) sq_q <= sq_q + mcand_q;
               mcand_q <= mcand_q << 1;
               mplr_q  <= mplr_q >> 1;
               bit_q   <= bit_q + BIT_W'(1);
            end
            S_SUB: begin
               if (!clear) begin
                  r_mean <= mean_q;
                  r_var  <= var_c;
                  r_min  <= min_q;
                  r_max  <= max_q;
                  r_tail <= tail_q;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_noise_stats_monitor.sv
// Directed bench for noise_stats_monitor with hand-computed window results.
module tb_noise_stats_monitor;

   localparam int unsigned N = 1024;

   logic        clk = 1'b0;
   logic        rst_n, start, clear, s_valid, s_ready, busy, r_valid, r_ready;
   logic [15:0] s_data, r_mean, r_min, r_max;
   logic [31:0] r_var;
   logic [10:0] r_tail;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   noise_stats_monitor dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .clear   (clear),
      .s_valid (s_valid),
      .s_ready (s_ready),
      .s_data  (s_data),
      .busy    (busy),
      .r_valid (r_valid),
      .r_ready (r_ready),
      .r_mean  (r_mean),
      .r_var   (r_var),
      .r_min   (r_min),
      .r_max   (r_max),
      .r_tail  (r_tail)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Offer one sample and hold it until the handshake completes.
   task automatic push(input logic [15:0] d);
      int guard;
      guard   = 0;
      s_valid = 1'b1;
      s_data  = d;
      while (!s_ready && guard < 50) begin
         tick();
         guard++;
      end
      if (!s_ready) chk("push_ready", s_ready, 1);
      tick();
      s_valid = 1'b0;
   endtask

   task automatic wait_result(input string tag, input int exp_lat);
      int lat;
      lat = 0;
      while (!r_valid && lat < 100) begin
         tick();
         lat++;
      end
      chk({tag, "_lat"}, lat, exp_lat);
   endtask

   task automatic check_res(input string tag, input logic [15:0] mean, input logic [31:0] var_v,
                            input logic [15:0] mn, input logic [15:0] mx, input logic [10:0] tail);
      chk({tag, "_valid"}, r_valid, 1);
      chk({tag, "_mean"}, r_mean, mean);
      chk({tag, "_var"}, r_var, var_v);
      chk({tag, "_min"}, r_min, mn);
      chk({tag, "_max"}, r_max, mx);
      chk({tag, "_tail"}, r_tail, tail);
   endtask

   task automatic accept(input string tag);
      r_ready = 1'b1;
      tick();
      r_ready = 1'b0;
      chk({tag, "_idle"}, busy, 0);
      chk({tag, "_rvalid_drop"}, r_valid, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired got timeout expected finish");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; start = 1'b0; clear = 1'b0;
      s_valid = 1'b0; s_data = '0; r_ready = 1'b0;
      #17;
      chk("rst_s_ready", s_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_r_valid", r_valid, 0);
      chk("rst_r_mean", r_mean, 0);
      chk("rst_r_var", r_var, 0);
      chk("rst_r_tail", r_tail, 0);
      rst_n = 1'b1;
      tick();

      // Constant 1.0 window.
      do_start();
      chk("t1_s_ready", s_ready, 1);
      chk("t1_busy", busy, 1);
      for (int i = 0; i < N; i++) push(16'h0800);
      wait_result("t1", 18);
      check_res("t1", 16'h0800, 32'h0, 16'h0800, 16'h0800, 11'd0);
      accept("t1");

      // Alternating +1.0 / -1.0.
      do_start();
      for (int i = 0; i < N; i++) push((i % 2 == 0) ? 16'h0800 : 16'hF800);
      wait_result("t2", 18);
      check_res("t2", 16'h0000, 32'h0040_0000, 16'hF800, 16'h0800, 11'd0);
      accept("t2");

      // Eight 4.0 samples then zeros; leave REPORT through clear.
      do_start();
      for (int i = 0; i < N; i++) push((i < 8) ? 16'h2000 : 16'h0000);
      wait_result("t3", 18);
      check_res("t3", 16'h0040, 32'h0007_F000, 16'h0000, 16'h2000, 11'd8);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      chk("t3_clear_rvalid", r_valid, 0);
      chk("t3_clear_busy", busy, 0);
      chk("t3_clear_mean_kept", r_mean, 16'h0040);
      chk("t3_clear_var_kept", r_var, 32'h0007_F000);

      // Extremes with random valid gaps; data offered in IDLE must be ignored.
      s_valid = 1'b1;
      s_data  = 16'h7FFF;
      repeat (3) tick();
      chk("t4_idle_no_ready", s_ready, 0);
      start = 1'b1;
      tick();
      start   = 1'b0;
      s_valid = 1'b0;
      for (int i = 0; i < N; i++) begin
         int g;
         g = $urandom_range(0, 2);
         repeat (g) begin
            s_data = 16'($urandom);
            tick();
         end
         if (i == N - 1) begin
            chk("t4_pre_last_ready", s_ready, 1);
            chk("t4_pre_last_rvalid", r_valid, 0);
         end
         push((i == 100) ? 16'h8000 : ((i == 700) ? 16'h7FFF : 16'h0000));
      end
      wait_result("t4", 18);
      check_res("t4", 16'h0000, 32'h001F_FFC0, 16'h8000, 16'h7FFF, 11'd2);

      // Hold REPORT with r_ready low and a stray start.
      for (int k = 0; k < 10; k++) begin
         start = (k == 3);
         tick();
         chk("t5_hold_rvalid", r_valid, 1);
         chk("t5_hold_s_ready", s_ready, 0);
         chk("t5_hold_var", r_var, 32'h001F_FFC0);
         chk("t5_hold_tail", r_tail, 11'd2);
      end
      start   = 1'b1;
      r_ready = 1'b1;
      tick();
      start   = 1'b0;
      r_ready = 1'b0;
      chk("t5_release_busy", busy, 0);
      chk("t5_release_rvalid", r_valid, 0);
      tick();
      chk("t5_start_ignored", busy, 0);
      chk("t5_no_s_ready", s_ready, 0);

      // clear beats start in IDLE.
      start = 1'b1;
      clear = 1'b1;
      tick();
      start = 1'b0;
      clear = 1'b0;
      chk("t6_clear_over_start", busy, 0);

      // Abort a partial window, then a clean one.
      do_start();
      for (int i = 0; i < 500; i++) push(16'h2000);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      chk("t6_abort_busy", busy, 0);
      chk("t6_abort_s_ready", s_ready, 0);
      do_start();
      for (int i = 0; i < N; i++) push(16'h0800);
      wait_result("t6", 18);
      check_res("t6", 16'h0800, 32'h0, 16'h0800, 16'h0800, 11'd0);
      accept("t6");

      // Asynchronous reset in the middle of the squaring phase.
      do_start();
      for (int i = 0; i < N; i++) push(16'h2000);
      repeat (5) tick();
      chk("t7_busy_in_sqr", busy, 1);
      #3;
      rst_n = 1'b0;
      #1;
      chk("t7_rst_s_ready", s_ready, 0);
      chk("t7_rst_busy", busy, 0);
      chk("t7_rst_r_valid", r_valid, 0);
      chk("t7_rst_r_mean", r_mean, 0);
      chk("t7_rst_r_var", r_var, 0);
      chk("t7_rst_r_min", r_min, 0);
      chk("t7_rst_r_max", r_max, 0);
      chk("t7_rst_r_tail", r_tail, 0);
      #2;
      rst_n = 1'b1;
      repeat (20) tick();
      chk("t7_post_busy", busy, 0);
      chk("t7_post_rvalid", r_valid, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
